// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: register index, scoreboard FSM encoding and pending-count limits.
package mips_core_pkg;

  typedef logic [4:0] MipsReg;

  localparam int NUM_REGS       = 32;
  localparam int SB_MAX_PENDING = 3;
  localparam int SB_CNT_W       = 2;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    DRAIN   = ST_DRAIN,
    DRAINED = ST_DRAINED
  } ScoreboardState;

  // One-hot select of a register; r0 maps to nothing since it is never tracked.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input MipsReg r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/sb_pending_counter.sv
// Saturating pending-write counter for one architectural register.
// Latency: count updates one edge after inc/dec; flags are decoded from the registered count.
// Backpressure: none; simultaneous inc+dec cancels, dec at zero and inc at full are dropped.
module sb_pending_counter
  import mips_core_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic full
);

  logic [SB_CNT_W-1:0] cnt;

  assign nonzero = (cnt != '0);
  assign full    = (cnt == SB_CNT_W'(SB_MAX_PENDING));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && nonzero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode/issue register scoreboard with drain FSM; optional stall statistics via SCOREBOARD_STATS_EN.
// Latency: issue/stall are combinational from registered counts; counts and state update next edge.
// Backpressure: holds the decoded instruction (stall) on hazard, !ex_ready or while draining.
module reg_scoreboard
  import mips_core_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   dec_valid,
  input  logic   dec_uses_rs,
  input  MipsReg dec_rs_addr,
  input  logic   dec_uses_rt,
  input  MipsReg dec_rt_addr,
  input  logic   dec_uses_rw,
  input  MipsReg dec_rw_addr,
  input  logic   ex_ready,
  input  logic   flush,
  input  logic   wb_valid,
  input  MipsReg wb_addr,
  input  logic   drain_req,
  output logic   issue,
  output logic   stall,
  output logic   drained
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  ScoreboardState state, state_nxt;

  logic [NUM_REGS-1:0] pend_nz;
  logic [NUM_REGS-1:0] pend_full;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                hazard;
  logic                all_idle;

  assign pend_nz[0]   = 1'b0;
  assign pend_full[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_pending_counter u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_vec[r]),
      .dec     (dec_vec[r]),
      .nonzero (pend_nz[r]),
      .full    (pend_full[r])
    );
  end

  // Hazards look only at registered counts, so a same-cycle writeback never unblocks.
  assign hazard = (dec_uses_rs && pend_nz[dec_rs_addr])
               || (dec_uses_rt && pend_nz[dec_rt_addr])
               || (dec_uses_rw && pend_full[dec_rw_addr]);

  assign issue    = dec_valid && ex_ready && !hazard && !flush && (state == RUN);
  assign stall    = dec_valid && !issue && !flush;
  assign all_idle = ~|pend_nz;

  assign inc_vec = (issue && dec_uses_rw) ? reg_onehot(dec_rw_addr) : '0;
  assign dec_vec = wb_valid ? reg_onehot(wb_addr) : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (!drain_req) state_nxt = RUN;
               else if (all_idle) state_nxt = DRAINED;
      DRAINED: if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      state   <= state_nxt;
      drained <= (state_nxt == DRAINED);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

  // A retire with nothing outstanding points at a pipeline bookkeeping bug upstream.
  always @(posedge clk) begin
    if (rst_n && wb_valid && (wb_addr != '0)) begin
      assert (pend_nz[wb_addr])
        else $warning("reg_scoreboard: writeback to idle register r%0d ignored", wb_addr);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, saturation, drain FSM, flush and async reset.
module tb_reg_scoreboard;
  import mips_core_pkg::*;

  logic   clk, rst_n;
  logic   dec_valid, dec_uses_rs, dec_uses_rt, dec_uses_rw;
  MipsReg dec_rs_addr, dec_rt_addr, dec_rw_addr;
  logic   ex_ready, flush, wb_valid, drain_req;
  MipsReg wb_addr;
  logic   issue, stall, drained;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_uses_rs (dec_uses_rs),
    .dec_rs_addr (dec_rs_addr),
    .dec_uses_rt (dec_uses_rt),
    .dec_rt_addr (dec_rt_addr),
    .dec_uses_rw (dec_uses_rw),
    .dec_rw_addr (dec_rw_addr),
    .ex_ready    (ex_ready),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .drain_req   (drain_req),
    .issue       (issue),
    .stall       (stall),
    .drained     (drained)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expected_finish observed_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_uses_rs = 0; dec_uses_rt = 0; dec_uses_rw = 0;
    dec_rs_addr = '0; dec_rt_addr = '0; dec_rw_addr = '0;
    ex_ready = 1; flush = 0; wb_valid = 0; wb_addr = '0;
  endtask

  task automatic writer(input MipsReg r);
    idle();
    dec_valid = 1; dec_uses_rw = 1; dec_rw_addr = r;
  endtask

  task automatic wb(input MipsReg r);
    wb_valid = 1; wb_addr = r;
  endtask

  // Reads pend[r] through the ports: a source read stalls iff nonzero, a write stalls iff full.
  task automatic probe(input MipsReg r, input logic exp_nz, input logic exp_full, input string tag);
    idle();
    dec_valid = 1; dec_uses_rs = 1; dec_rs_addr = r;
    #1 chk({tag, ".busy"}, stall, exp_nz);
    dec_uses_rs = 0; dec_uses_rw = 1; dec_rw_addr = r;
    #1 chk({tag, ".full"}, stall, exp_full);
    idle();
  endtask

  initial begin
    rst_n = 0; drain_req = 0;
    idle();
    #2;
    dec_valid = 1;
    #1;
    chk("rst.issue", issue, 1);
    chk("rst.stall", stall, 0);
    chk("rst.drained", drained, 0);
    idle();
    #4 rst_n = 1;
    tick();

    // RAW hazard on r5 until its writeback retires
    writer(5);
    #1 chk("raw.issue_w", issue, 1);
    tick();
    idle(); dec_valid = 1; dec_uses_rs = 1; dec_rs_addr = 5;
    #1 chk("raw.stall0", stall, 1);
    chk("raw.issue0", issue, 0);
    tick();
    chk("raw.stall1", stall, 1);
    wb(5);
    #1 chk("raw.stall_wb", stall, 1);
    chk("raw.issue_wb", issue, 0);
    tick();
    wb_valid = 0;
    chk("raw.issue_after", issue, 1);
    chk("raw.stall_after", stall, 0);
    tick();
    probe(5, 0, 0, "raw.p5");

    // Saturation: three writers to r7, fourth waits for one retire
    writer(7);
    for (int i = 0; i < 3; i++) begin
      #1 chk("sat.issue_n", issue, 1);
      tick();
    end
    chk("sat.stall4", stall, 1);
    chk("sat.issue4", issue, 0);
    wb(7);
    #1 chk("sat.stall_wb", stall, 1);
    tick();
    wb_valid = 0;
    chk("sat.issue4_go", issue, 1);
    tick();
    probe(7, 1, 1, "sat.p7");
    wb(7);
    for (int i = 0; i < 3; i++) tick();
    wb_valid = 0;
    probe(7, 0, 0, "sat.p7_empty");

    // Simultaneous inc/dec, r0 and idle-register writebacks
    writer(9);
    tick();
    wb(9);
    #1 chk("same.issue", issue, 1);
    tick();
    probe(9, 1, 0, "same.p9");
    wb(0);
    tick();
    wb_valid = 0;
    probe(9, 1, 0, "r0wb.p9");
    wb(9);
    tick();
    wb(9);
    tick();
    wb_valid = 0;
    probe(9, 0, 0, "underflow.p9");

    // Drain with two writes outstanding
    writer(3);
    tick();
    writer(4);
    tick();
    idle(); drain_req = 1;
    tick();
    dec_valid = 1;
    #1 chk("drain.issue", issue, 0);
    chk("drain.stall", stall, 1);
    chk("drain.drained0", drained, 0);
    idle(); wb(3);
    tick();
    wb(4);
    tick();
    wb_valid = 0;
    chk("drain.drained_wait", drained, 0);
    tick();
    chk("drain.drained1", drained, 1);
    dec_valid = 1;
    #1 chk("drained.issue", issue, 0);
    drain_req = 0;
    #1 chk("drained.issue_req0", issue, 0);
    tick();
    chk("resume.drained", drained, 0);
    chk("resume.issue", issue, 1);
    idle();
    tick();

    // Drain aborted before counts reach zero
    writer(6);
    tick();
    idle(); drain_req = 1;
    tick();
    dec_valid = 1;
    #1 chk("abort.issue_drain", issue, 0);
    drain_req = 0;
    tick();
    chk("abort.drained", drained, 0);
    chk("abort.issue_run", issue, 1);
    idle(); wb(6);
    tick();
    wb_valid = 0;
    probe(6, 0, 0, "abort.p6");

    // r0 source, flush and ex_ready gating
    idle(); dec_valid = 1; dec_uses_rs = 1; dec_rs_addr = 0;
    #1 chk("r0src.issue", issue, 1);
    chk("r0src.stall", stall, 0);
    flush = 1;
    #1 chk("flush.issue", issue, 0);
    chk("flush.stall", stall, 0);
    flush = 0; ex_ready = 0;
    #1 chk("exrdy.stall", stall, 1);
    chk("exrdy.issue", issue, 0);
    writer(0);
    tick();
    probe(0, 0, 0, "r0dst.p0");

    // Async reset clears counts and statistics without a clock edge
    rst_n = 0;
    #1 rst_n = 1;
    writer(12);
    tick();
    idle(); dec_valid = 1; ex_ready = 0;
    for (int i = 0; i < 4; i++) tick();
`ifdef SCOREBOARD_STATS_EN
    chk("stats.count4", stall_count, 32'd4);
`endif
    idle();
    #1 rst_n = 0;
    #1;
`ifdef SCOREBOARD_STATS_EN
    chk("stats.async_clr", stall_count, 32'd0);
`endif
    chk("arst.drained", drained, 0);
    probe(12, 0, 0, "arst.p12");
    #1 rst_n = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
